// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
//
// Purpose:
//   Byte-addressable data memory of 4096 x 32-bit words with word, half-word
//   and byte loads/stores. Loads are combinational from the array, with zero
//   or sign extension. Stores are byte-lane masked and take effect at the
//   rising clock edge, so a load to the word being stored returns the old
//   contents in that cycle.
//
// Configuration:
//   DM_ALIGN_CHECK_EN - when defined, misaligned accesses, out-of-segment
//                       addresses (>= 0x0000_4000) and reserved ops raise
//                       fault, suppress the store, force rdata to 0 and bump
//                       a saturating fault counter. When undefined, fault
//                       and fault_cnt are tied to 0 and the address bits that
//                       do not apply to the access are ignored.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous active-high reset; clears memory and counter
//   we         in   1   store enable
//   op         in   3   000 word, 001 half u, 010 half s, 011 byte u, 100 byte s
//   addr       in  32   byte address
//   wdata      in  32   store data, right-aligned
//   rdata      out 32   load result, extended to 32 bits
//   fault      out  1   current access is illegal
//   fault_cnt  out  8   saturating count of faulting cycles
// -----------------------------------------------------------------------------
module data_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [7:0]  fault_cnt
);

  localparam int unsigned DEPTH = 4096;

  localparam logic [2:0] OP_WORD   = 3'b000;
  localparam logic [2:0] OP_HALF_U = 3'b001;
  localparam logic [2:0] OP_HALF_S = 3'b010;
  localparam logic [2:0] OP_BYTE_U = 3'b011;
  localparam logic [2:0] OP_BYTE_S = 3'b100;

  logic [31:0] r_mem [0:DEPTH-1];

  logic [11:0] w_idx;
  logic [31:0] w_word;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic        w_is_word;
  logic        w_is_half;
  logic        w_is_byte;
  logic        w_reserved;
  logic        w_fault;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_lanes;

  assign w_idx  = addr[13:2];
  assign w_word = r_mem[w_idx];

  assign w_is_word  = (op == OP_WORD);
  assign w_is_half  = (op == OP_HALF_U) || (op == OP_HALF_S);
  assign w_is_byte  = (op == OP_BYTE_U) || (op == OP_BYTE_S);
  assign w_reserved = !(w_is_word || w_is_half || w_is_byte);

  // Lane selection for sub-word loads.
  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];
  always_comb begin
    w_byte = w_word[7:0];
    case (addr[1:0])
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

`ifdef DM_ALIGN_CHECK_EN
  assign w_fault = w_reserved
                 || (w_is_word && (addr[1:0] != 2'b00))
                 || (w_is_half && addr[0])
                 || (addr[31:14] != 18'd0);
`else
  assign w_fault = 1'b0;
  // Upper address bits are don't-care when checking is disabled.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = |addr[31:14];
`endif

  // Load extension; reserved ops and faulting accesses read as 0.
  always_comb begin
    w_load = 32'd0;
    case (op)
      OP_WORD:   w_load = w_word;
      OP_HALF_U: w_load = {16'd0, w_half};
      OP_HALF_S: w_load = {{16{w_half[15]}}, w_half};
      OP_BYTE_U: w_load = {24'd0, w_byte};
      OP_BYTE_S: w_load = {{24{w_byte[7]}}, w_byte};
      default:   w_load = 32'd0;
    endcase
    if (w_fault) begin
      w_load = 32'd0;
    end
  end

  assign rdata = w_load;
  assign fault = w_fault;

  // Store byte enables and lane-replicated store data; reserved ops write
  // nothing.
  always_comb begin
    w_be          = 4'b0000;
    w_wdata_lanes = wdata;
    if (w_is_word) begin
      w_be          = 4'b1111;
      w_wdata_lanes = wdata;
    end else if (w_is_half) begin
      w_be          = addr[1] ? 4'b1100 : 4'b0011;
      w_wdata_lanes = {wdata[15:0], wdata[15:0]};
    end else if (w_is_byte) begin
      w_be          = 4'b0001 << addr[1:0];
      w_wdata_lanes = {4{wdata[7:0]}};
    end
  end

  // Reset clears the whole array in one edge, which is why this is built
  // from registers rather than a block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
        end
      end
    end
  end

`ifdef DM_ALIGN_CHECK_EN
  logic [7:0] r_fault_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault_cnt <= 8'd0;
    end else if (w_fault && (r_fault_cnt != 8'hFF)) begin
      r_fault_cnt <= r_fault_cnt + 8'd1;
    end
  end

  assign fault_cnt = r_fault_cnt;
`else
  assign fault_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
//
// Directed testbench for data_mem: reset clearing, word/half/byte loads with
// zero and sign extension, masked sub-word stores, same-cycle read-during-
// write, back-to-back stores, reserved ops, and the alignment-check
// configuration selected by DM_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        fault;
  logic [7:0]  fault_cnt;

  int checks;
  int failures;

  data_mem dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .fault     (fault),
    .fault_cnt (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-16s addr=0x%08h op=%0d we=%0d obs=0x%08h exp=0x%08h",
             tag, addr, op, we, obs, exp);
  endtask

  // Apply inputs away from the clock edge and let combinational logic settle.
  task automatic drive(input logic w, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] d);
    we    = w;
    op    = o;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    reset = 1'b0;

    // Put data in, then reset with a concurrent store: both must vanish.
    drive(1'b1, 3'd0, 32'h0000_0050, 32'h1122_3344);
    step();
    drive(1'b0, 3'd0, 32'h0000_0050, 32'h0);
    check("pre_reset_word", rdata, 32'h1122_3344);
    reset = 1'b1;
    drive(1'b1, 3'd0, 32'h0000_0010, 32'hDEAD_BEEF);
    step();
    reset = 1'b0;

    drive(1'b0, 3'd0, 32'h0000_0000, 32'h0);
    check("rst_word_0", rdata, 32'h0);
    check("rst_fault_cnt", {24'd0, fault_cnt}, 32'h0);
    check("rst_fault", {31'd0, fault}, 32'h0);
    drive(1'b0, 3'd3, 32'h0000_3FFF, 32'h0);
    check("rst_byte_3fff", rdata, 32'h0);
    drive(1'b0, 3'd0, 32'h0000_0050, 32'h0);
    check("rst_cleared", rdata, 32'h0);
    drive(1'b0, 3'd0, 32'h0000_0010, 32'h0);
    check("rst_store_drop", rdata, 32'h0);

    // Loads with extension from a known word.
    drive(1'b1, 3'd0, 32'h0000_0010, 32'h8765_4321);
    step();
    drive(1'b0, 3'd3, 32'h0000_0013, 32'h0);
    check("lbu_13", rdata, 32'h0000_0087);
    drive(1'b0, 3'd4, 32'h0000_0013, 32'h0);
    check("lb_13", rdata, 32'hFFFF_FF87);
    drive(1'b0, 3'd2, 32'h0000_0012, 32'h0);
    check("lh_12", rdata, 32'hFFFF_8765);
    drive(1'b0, 3'd1, 32'h0000_0010, 32'h0);
    check("lhu_10", rdata, 32'h0000_4321);
    drive(1'b0, 3'd2, 32'h0000_0010, 32'h0);
    check("lh_10", rdata, 32'h0000_4321);
    drive(1'b0, 3'd1, 32'h0000_0012, 32'h0);
    check("lhu_12", rdata, 32'h0000_8765);
    drive(1'b0, 3'd4, 32'h0000_0010, 32'h0);
    check("lb_10", rdata, 32'h0000_0021);
    drive(1'b0, 3'd3, 32'h0000_0011, 32'h0);
    check("lbu_11", rdata, 32'h0000_0043);
    drive(1'b0, 3'd3, 32'h0000_0012, 32'h0);
    check("lbu_12", rdata, 32'h0000_0065);
    drive(1'b0, 3'd5, 32'h0000_0010, 32'h0);
    check("rsv_read", rdata, 32'h0);
    drive(1'b0, 3'd0, 32'h0000_0010, 32'h0);
    check("lw_10", rdata, 32'h8765_4321);

    // Masked sub-word stores; upper wdata bits must be ignored.
    drive(1'b1, 3'd0, 32'h0000_0020, 32'hFFFF_FFFF);
    step();
    drive(1'b1, 3'd3, 32'h0000_0021, 32'hAAAA_AA12);
    step();
    drive(1'b0, 3'd0, 32'h0000_0020, 32'h0);
    check("sb_21", rdata, 32'hFFFF_12FF);
    drive(1'b1, 3'd2, 32'h0000_0022, 32'h5555_BEEF);
    step();
    drive(1'b0, 3'd0, 32'h0000_0020, 32'h0);
    check("sh_22", rdata, 32'hBEEF_12FF);
    drive(1'b1, 3'd4, 32'h0000_0020, 32'h0000_0000);
    step();
    drive(1'b0, 3'd0, 32'h0000_0020, 32'h0);
    check("sb_20", rdata, 32'hBEEF_1200);
    drive(1'b1, 3'd7, 32'h0000_0020, 32'h0000_0000);
    step();
    drive(1'b0, 3'd0, 32'h0000_0020, 32'h0);
    check("rsv_no_write", rdata, 32'hBEEF_1200);

    // Read-during-write returns old data; new data visible next cycle.
    drive(1'b1, 3'd0, 32'h0000_0030, 32'hCAFE_F00D);
    check("rdw_old", rdata, 32'h0);
    step();
    drive(1'b0, 3'd0, 32'h0000_0030, 32'h0);
    check("rdw_new", rdata, 32'hCAFE_F00D);

    // Back-to-back stores.
    drive(1'b1, 3'd0, 32'h0000_0100, 32'h0000_0001);
    step();
    drive(1'b1, 3'd0, 32'h0000_0104, 32'h0000_0002);
    step();
    drive(1'b1, 3'd0, 32'h0000_0108, 32'h0000_0003);
    step();
    drive(1'b0, 3'd0, 32'h0000_0100, 32'h0);
    check("b2b_0", rdata, 32'h0000_0001);
    drive(1'b0, 3'd0, 32'h0000_0104, 32'h0);
    check("b2b_1", rdata, 32'h0000_0002);
    drive(1'b0, 3'd0, 32'h0000_0108, 32'h0);
    check("b2b_2", rdata, 32'h0000_0003);

`ifdef DM_ALIGN_CHECK_EN
    drive(1'b1, 3'd0, 32'h0000_0042, 32'hA5A5_A5A5);
    check("flt_mis_word", {31'd0, fault}, 32'h1);
    check("flt_rdata", rdata, 32'h0);
    step();
    drive(1'b0, 3'd0, 32'h0000_0040, 32'h0);
    check("flt_no_write", rdata, 32'h0);
    check("flt_cnt_1", {24'd0, fault_cnt}, 32'h1);
    drive(1'b0, 3'd0, 32'h0000_4000, 32'h0);
    check("flt_range", {31'd0, fault}, 32'h1);
    drive(1'b0, 3'd1, 32'h0000_0041, 32'h0);
    check("flt_mis_half", {31'd0, fault}, 32'h1);
    drive(1'b0, 3'd6, 32'h0000_0040, 32'h0);
    check("flt_rsv", {31'd0, fault}, 32'h1);
    for (int i = 0; i < 300; i++) begin
      step();
    end
    check("flt_cnt_sat", {24'd0, fault_cnt}, 32'h0000_00FF);
`else
    drive(1'b1, 3'd0, 32'h0000_0042, 32'hA5A5_A5A5);
    check("nf_fault", {31'd0, fault}, 32'h0);
    step();
    drive(1'b0, 3'd0, 32'h0000_0040, 32'h0);
    check("nf_word_40", rdata, 32'hA5A5_A5A5);
    drive(1'b0, 3'd0, 32'hFFFF_C043, 32'h0);
    check("nf_hi_ignored", rdata, 32'hA5A5_A5A5);
    drive(1'b0, 3'd1, 32'h0000_0041, 32'h0);
    check("nf_half_odd", rdata, 32'h0000_A5A5);
    check("nf_fault_cnt", {24'd0, fault_cnt}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have these ports: clk  input  1  rising-edge clock.
REQ-002 reset  input  1  synchronous, active-high reset; clock clk.
REQ-003 we  input  1  store enable, sampled on the rising edge of clk.
REQ-004 op  input  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101-111 reserved.
REQ-005 addr  input  32  byte address, data segment based at 0x0000_0000.
REQ-006 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 rdata  output  32  load result, extended to 32 bits per op.
REQ-008 fault  output  1  current access is illegal (meaningful only with DM_ALIGN_CHECK_EN).
REQ-009 fault_cnt  output  8  saturating count of faulting accesses.

Function
REQ-010 Storage SHALL be 4096 x 32-bit words, indexed by addr[13:2].
REQ-011 Reads SHALL be combinational from the array: rdata reflects the contents at addr and op in the same cycle, with no clock latency.
REQ-012 Word load SHALL return the full word.
REQ-013 Half load SHALL select bits [31:16] when addr[1]=1, else bits [15:0], then zero-extend (op 001) or sign-extend (op 010).
REQ-014 Byte load SHALL select byte lane addr[1:0] (lane 0 = bits [7:0]), then zero-extend (op 011) or sign-extend (op 100).
REQ-015 A store SHALL update memory at the rising edge of clk when we=1, reset=0 and fault=0.
REQ-016 Word store SHALL write all 4 bytes.
REQ-017 Half store (op 001 or 010) SHALL write only the 2 bytes selected by addr[1]; the other bytes are preserved.
REQ-018 Byte store (op 011 or 100) SHALL write only lane addr[1:0]; the other 3 bytes are preserved.
REQ-019 A reserved op SHALL read 0, SHALL perform no write, and SHALL count as a fault when the check is enabled.
REQ-020 A load in the same cycle as a store to the same word SHALL return the old contents; the new data is visible from the next cycle.
REQ-021 fault_cnt SHALL increment by 1 on each rising edge where fault=1, and SHALL saturate at 0xFF.
REQ-022 Back-to-back stores on consecutive cycles SHALL each take effect; there is no stall and no backpressure.

Reset
REQ-023 When reset=1 at a rising edge, all 4096 words SHALL become 0 and fault_cnt SHALL become 0.
REQ-024 A store presented in the same cycle as reset SHALL be discarded.
REQ-025 After reset, rdata SHALL read 0 for every address and op.

Configuration
REQ-026 Macro DM_ALIGN_CHECK_EN SHALL control whether illegal accesses are detected.
REQ-027 With the macro defined, fault SHALL be 1 when any of these holds: a word access with addr[1:0]!=0, a half access with addr[0]=1, addr >= 0x0000_4000, or a reserved op.
REQ-028 With the macro defined and fault=1, the store SHALL be suppressed and rdata SHALL be 0.
REQ-029 With the macro undefined, fault SHALL be tied 0 and fault_cnt SHALL remain 0.
REQ-030 With the macro undefined, address bits that do not apply SHALL be ignored: word accesses ignore addr[1:0], half accesses ignore addr[0], and addr[31:14] is ignored.

Verification
REQ-031 Reset, then load word at 0x0000 and byte at 0x3FFF -> both return 0x0000_0000, and fault_cnt = 0.
REQ-032 Store word 0x8765_4321 at 0x0010, then load: op 011 at 0x0013 -> 0x0000_0087; op 100 at 0x0013 -> 0xFFFF_FF87; op 010 at 0x0012 -> 0xFFFF_8765; op 001 at 0x0010 -> 0x0000_4321.
REQ-033 Store word 0xFFFF_FFFF at 0x0020, then store byte 0x12 at 0x0021 -> word load at 0x0020 returns 0xFFFF_12FF.
REQ-034 Store and load word at 0x0030 in the same cycle (prior contents 0) -> load returns 0 in that cycle and the new value on the next cycle.
REQ-035 With DM_ALIGN_CHECK_EN: store word at 0x0042 -> fault=1, memory unchanged, fault_cnt 0->1; 300 consecutive faulting cycles -> fault_cnt holds at 0xFF.
REQ-036 Without DM_ALIGN_CHECK_EN: store word 0xA5A5_A5A5 at 0x0042 -> word load at 0x0040 returns 0xA5A5_A5A5, and fault stays 0.
